// File: rtl/flash_burst_writer_pkg.sv
// Shared types and constants for the flash_mem Avalon-MM burst writer.
// Bus widths match the flash_mem slave port; single-word transfers only.
package flash_pkg;
    localparam int           FLASH_AW   = 23;
    localparam int           FLASH_DW   = 32;
    localparam logic [3:0]   BYTEEN_ALL = 4'hF;
    localparam logic [6:0]   BURST_ONE  = 7'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_FIN
    } fw_state_t;
endpackage

// File: rtl/flash_burst_writer_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push/pop same cycle allowed.
// Zero-latency head after a push lands; push is refused upstream via full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign head  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/flash_burst_writer.sv
// Streams a block of words into flash_mem, then optionally reads it back and compares sums.
// >=1 cycle per write, >=2 per read; din_ready drops only when the input FIFO is full.
module flash_burst_writer
    import flash_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit VERIFY     = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic [FLASH_AW-1:0] base_addr,
    input  logic [7:0]          word_count,
    input  logic [FLASH_DW-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                flash_mem_write,
    output logic                flash_mem_read,
    output logic [FLASH_AW-1:0] flash_mem_address,
    output logic [FLASH_DW-1:0] flash_mem_writedata,
    output logic [3:0]          flash_mem_byteenable,
    output logic [6:0]          flash_mem_burstcount,
    input  logic                flash_mem_waitrequest,
    input  logic [FLASH_DW-1:0] flash_mem_readdata,
    input  logic                flash_mem_readdatavalid
);
    localparam int TW = $clog2(TIMEOUT + 1);

    fw_state_t           r_state, w_state_nxt;
    logic [FLASH_AW-1:0] r_base;
    logic [7:0]          r_count, r_idx;
    logic [FLASH_DW-1:0] r_sum_wr, r_sum_rd;
    logic                r_err;
    logic [TW-1:0]       r_wait;

    logic [FLASH_DW-1:0] w_fifo_head;
    logic                w_fifo_full, w_fifo_empty, w_push;
    logic                w_wr_xfer, w_rd_xfer, w_rd_data, w_stall, w_tmo, w_last;

    sync_fifo #(.WIDTH(FLASH_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset_n),
        .push  (w_push),
        .pop   (w_wr_xfer),
        .din   (din),
        .head  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign din_ready = !w_fifo_full;
    assign w_push    = din_valid && !w_fifo_full;
    assign w_last    = (r_idx == r_count - 8'd1);
    assign w_wr_xfer = (r_state == ST_WR) && !w_fifo_empty && !flash_mem_waitrequest;
    assign w_rd_xfer = (r_state == ST_RD_REQ) && !flash_mem_waitrequest;
    assign w_rd_data = (r_state == ST_RD_WAIT) && flash_mem_readdatavalid;
    // An empty FIFO in WR is not a stall: the stream side may idle indefinitely.
    assign w_stall   = ((r_state == ST_WR) && !w_fifo_empty && flash_mem_waitrequest) ||
                       ((r_state == ST_RD_REQ) && flash_mem_waitrequest) ||
                       ((r_state == ST_RD_WAIT) && !flash_mem_readdatavalid);
    assign w_tmo     = w_stall && (r_wait == TW'(TIMEOUT - 1));

    assign busy                 = (r_state != ST_IDLE);
    assign err                  = r_err;
    assign flash_mem_address    = r_base + {{(FLASH_AW-8){1'b0}}, r_idx};
    assign flash_mem_writedata  = flash_mem_write ? w_fifo_head : '0;
    assign flash_mem_byteenable = BYTEEN_ALL;
    assign flash_mem_burstcount = BURST_ONE;

    always_comb begin
        w_state_nxt     = r_state;
        flash_mem_write = 1'b0;
        flash_mem_read  = 1'b0;
        done            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (word_count == 8'd0) ? ST_FIN : ST_WR;
            end
            ST_WR: begin
                flash_mem_write = !w_fifo_empty;
                if (w_tmo)                   w_state_nxt = ST_FIN;
                else if (w_wr_xfer && w_last) w_state_nxt = VERIFY ? ST_RD_REQ : ST_FIN;
            end
            ST_RD_REQ: begin
                flash_mem_read = 1'b1;
                if (w_tmo)          w_state_nxt = ST_FIN;
                else if (w_rd_xfer) w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_tmo)          w_state_nxt = ST_FIN;
                else if (w_rd_data) w_state_nxt = w_last ? ST_FIN : ST_RD_REQ;
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset_n) begin
        if (reset_reset_n) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_sum_wr <= '0;
            r_sum_rd <= '0;
            r_err    <= 1'b0;
            r_wait   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && start) begin
                r_base   <= base_addr;
                r_count  <= word_count;
                r_idx    <= '0;
                r_sum_wr <= '0;
                r_sum_rd <= '0;
                r_err    <= 1'b0;
            end
            // Index restarts at zero for the read-back pass after the last write.
            if (w_wr_xfer) begin
                r_sum_wr <= r_sum_wr + w_fifo_head;
                r_idx    <= w_last ? 8'd0 : r_idx + 8'd1;
            end
            if (w_rd_data) begin
                r_sum_rd <= r_sum_rd + flash_mem_readdata;
                r_idx    <= r_idx + 8'd1;
            end
            if (w_tmo) r_err <= 1'b1;
            if ((r_state == ST_FIN) && VERIFY && (r_sum_rd != r_sum_wr)) r_err <= 1'b1;
            if ((w_state_nxt != r_state) || w_wr_xfer || w_rd_data) r_wait <= '0;
            else if (w_stall)                                       r_wait <= r_wait + TW'(1);
        end
    end
endmodule

// File: tb/tb_flash_burst_writer.sv
// Bench: flash slave with writable memory and stall control, plus a transaction-level model.
module tb_flash_burst_writer;
    localparam int TMO = 255;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b1;
    logic        start = 1'b0;
    logic [22:0] base_addr = '0;
    logic [7:0]  word_count = '0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready, busy, done, err;
    logic        flash_mem_write, flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [31:0] flash_mem_writedata;
    logic [3:0]  flash_mem_byteenable;
    logic [6:0]  flash_mem_burstcount;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;

    always #5 clk_clk = ~clk_clk;

    flash_burst_writer #(.FIFO_DEPTH(4), .VERIFY(1'b1), .TIMEOUT(TMO)) dut (
        .clk_clk                 (clk_clk),
        .reset_reset_n           (reset_reset_n),
        .start                   (start),
        .base_addr               (base_addr),
        .word_count              (word_count),
        .din                     (din),
        .din_valid               (din_valid),
        .din_ready               (din_ready),
        .busy                    (busy),
        .done                    (done),
        .err                     (err),
        .flash_mem_write         (flash_mem_write),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_writedata     (flash_mem_writedata),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Job-level model: what the slave must see, in order, for the current job.
    logic [22:0] m_base;
    int          m_count;
    logic [31:0] m_words[$];
    logic [22:0] wr_addr_log[$];
    logic [31:0] mem [int];
    int          stall_cfg, stall_left, corrupt_idx;
    int          wr_k, rd_k, wr_cycles, req_cycles;
    bit          no_rdv, rdv_pend, prev_stall;
    logic [31:0] rdv_data, wr_sum, ret_sum, d_tmp;
    logic        p_write, p_read;
    logic [22:0] p_addr;
    logic [31:0] p_wdata;

    function automatic logic [22:0] exp_addr(input logic [22:0] b, input int k);
        return b + k[22:0];
    endfunction

    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Compare + slave process: one pass per cycle, away from the active edge.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            flash_mem_waitrequest   = 1'b0;
            flash_mem_readdatavalid = 1'b0;
            rdv_pend   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (flash_mem_write && flash_mem_read) chk("wr_rd_exclusive", 1, 0);
            if (prev_stall) begin
                chk("stall_write", flash_mem_write, p_write);
                chk("stall_read", flash_mem_read, p_read);
                chk("stall_addr", flash_mem_address, p_addr);
                chk("stall_wdata", flash_mem_writedata, p_wdata);
            end
            if (rdv_pend) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata      = rdv_data;
                rdv_pend                = 1'b0;
            end else begin
                flash_mem_readdatavalid = 1'b0;
                flash_mem_readdata      = 32'h0;
            end
            if (flash_mem_write || flash_mem_read) begin
                chk("byteenable", flash_mem_byteenable, 4'hF);
                chk("burstcount", flash_mem_burstcount, 7'd1);
                req_cycles++;
                if (flash_mem_write) wr_cycles++;
                if (stall_left > 0) begin
                    flash_mem_waitrequest = 1'b1;
                    stall_left--;
                    prev_stall = 1'b1;
                    p_write = flash_mem_write;
                    p_read  = flash_mem_read;
                    p_addr  = flash_mem_address;
                    p_wdata = flash_mem_writedata;
                end else begin
                    flash_mem_waitrequest = 1'b0;
                    prev_stall = 1'b0;
                    stall_left = stall_cfg;
                    if (flash_mem_write) begin
                        chk("wr_addr", flash_mem_address, exp_addr(m_base, wr_k));
                        if (wr_k < m_count) chk("wr_data", flash_mem_writedata, m_words[wr_k]);
                        else                chk("wr_extra", wr_k, m_count);
                        mem[int'(flash_mem_address)] = flash_mem_writedata;
                        wr_addr_log.push_back(flash_mem_address);
                        wr_sum += flash_mem_writedata;
                        wr_k++;
                    end else begin
                        chk("rd_addr", flash_mem_address, exp_addr(m_base, rd_k));
                        d_tmp = (rd_k == corrupt_idx) ? 32'hDEAD : mem_rd(int'(flash_mem_address));
                        if (!no_rdv) begin
                            rdv_pend = 1'b1;
                            rdv_data = d_tmp;
                            ret_sum += d_tmp;
                        end
                        rd_k++;
                    end
                end
            end else begin
                flash_mem_waitrequest = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run_job(input logic [22:0] b, input int cnt, input int stall, input int corr,
                           input bit nordv, output int lat);
        bit got;
        m_base = b; m_count = cnt; stall_cfg = stall; stall_left = stall;
        corrupt_idx = corr; no_rdv = nordv;
        wr_k = 0; rd_k = 0; wr_sum = 0; ret_sum = 0; wr_cycles = 0; req_cycles = 0;
        wr_addr_log.delete();
        @(posedge clk_clk); #1;
        base_addr = b; word_count = cnt[7:0]; start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
        got = 1'b0; lat = 0;
        fork
            begin
                for (int i = 0; i < cnt; i++) begin
                    din = m_words[i]; din_valid = 1'b1;
                    for (int w = 0; w < 1000; w++) begin
                        @(negedge clk_clk);
                        if (din_ready) break;
                    end
                    if (!din_ready) chk("din_ready_wait", 0, 1);
                    @(posedge clk_clk); #1;
                end
                din_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 3000 && !got; c++) begin
                    @(negedge clk_clk);
                    if (done) begin
                        got = 1'b1; lat = c;
                        chk("busy_at_done", busy, 1);
                    end
                end
            end
        join
        chk("done_seen", got, 1);
        @(negedge clk_clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("err_model", err, (ret_sum != wr_sum) || nordv);
        chk("write_count", wr_k, cnt);
        if (!nordv) chk("read_count", rd_k, cnt);
    endtask

    int lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_clk);
        chk("rst_write", flash_mem_write, 0);
        chk("rst_read", flash_mem_read, 0);
        chk("rst_addr", flash_mem_address, 0);
        chk("rst_wdata", flash_mem_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_din_ready", din_ready, 1);
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b0;

        // 1: plain 4-word job, no stalls
        m_words = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_job(23'h10, 4, 0, -1, 1'b0, lat);
        chk("t1_latency", lat, 14);
        chk("t1_mem13", mem_rd(32'h13), 32'h4);
        chk("t1_first_addr", wr_addr_log[0], 23'h10);
        chk("t1_err", err, 0);

        // 2: three stall cycles on every transfer
        m_words = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
        run_job(23'h40, 3, 3, -1, 1'b0, lat);
        chk("t2_write_cycles", wr_cycles, 12);
        chk("t2_req_cycles", req_cycles, 24);

        // 3: slave corrupts read-back of word 2
        m_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_job(23'h100, 4, 0, 2, 1'b0, lat);
        chk("t3_err", err, 1);

        // 4: zero-length job clears err, no bus activity
        m_words = {};
        run_job(23'h200, 0, 0, -1, 1'b0, lat);
        chk("t4_latency", lat, 1);
        chk("t4_no_requests", req_cycles, 0);
        chk("t4_err_cleared", err, 0);

        // 5: address wrap
        m_words = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002};
        run_job(23'h7FFFFE, 3, 1, -1, 1'b0, lat);
        chk("t5_addr0", wr_addr_log[0], 23'h7FFFFE);
        chk("t5_addr1", wr_addr_log[1], 23'h7FFFFF);
        chk("t5_addr2", wr_addr_log[2], 23'h000000);
        chk("t5_mem0", mem_rd(0), 32'hCAFE0002);

        // 6a: readdatavalid never returned -> timeout
        m_words = '{32'h0BADF00D};
        run_job(23'h5, 1, 0, -1, 1'b1, lat);
        chk("t6_err", err, 1);
        chk("t6_lat_min", lat >= TMO + 2, 1);
        chk("t6_lat_max", lat <= TMO + 6, 1);

        // 6b: reset during a stalled write
        m_words = '{32'h12345678}; m_base = 23'h300; m_count = 4;
        stall_cfg = 50; stall_left = 50; wr_k = 0; rd_k = 0; corrupt_idx = -1; no_rdv = 1'b0;
        @(posedge clk_clk); #1;
        base_addr = 23'h300; word_count = 8'd4; start = 1'b1; din = 32'h12345678; din_valid = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0; din_valid = 1'b0;
        repeat (4) @(negedge clk_clk);
        chk("t6_write_stalled", flash_mem_write, 1);
        #2 reset_reset_n = 1'b1;
        @(negedge clk_clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_write", flash_mem_write, 0);
        chk("t6_rst_addr", flash_mem_address, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_din_ready", din_ready, 1);
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_clk);
            chk("t6_no_done_after_rst", done, 0);
            chk("t6_idle_after_rst", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
